// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit with architectural HI/LO for the EX stage.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring), serves MFHI/MFLO/MTHI/MTLO,
// and requests a pipeline stall while a dependent HI/LO instruction must wait.
// Build option: define MULDIV_RADIX4_EN to retire two multiplier bits per cycle
// (16-cycle multiply); divide is unaffected.
module ex_muldiv_unit #(
  parameter int unsigned SIZE     = 32,
  parameter int unsigned SIZE_FNC = 6,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                md_valid,
  input  logic [SIZE_FNC-1:0] funcion,
  input  logic [SIZE-1:0]     op_a,
  input  logic [SIZE-1:0]     op_b,
  output logic                md_stall,
  output logic                busy,
  output logic [SIZE-1:0]     mf_result,
  output logic [SIZE-1:0]     hi,
  output logic [SIZE-1:0]     lo
);

  localparam int unsigned PW = 2 * SIZE;

  localparam logic [SIZE_FNC-1:0] F_MFHI  = SIZE_FNC'(6'h10);
  localparam logic [SIZE_FNC-1:0] F_MTHI  = SIZE_FNC'(6'h11);
  localparam logic [SIZE_FNC-1:0] F_MFLO  = SIZE_FNC'(6'h12);
  localparam logic [SIZE_FNC-1:0] F_MTLO  = SIZE_FNC'(6'h13);
  localparam logic [SIZE_FNC-1:0] F_MULT  = SIZE_FNC'(6'h18);
  localparam logic [SIZE_FNC-1:0] F_MULTU = SIZE_FNC'(6'h19);
  localparam logic [SIZE_FNC-1:0] F_DIV   = SIZE_FNC'(6'h1A);
  localparam logic [SIZE_FNC-1:0] F_DIVU  = SIZE_FNC'(6'h1B);

`ifdef MULDIV_RADIX4_EN
  localparam int unsigned MUL_ITER = SIZE / 2;
`else
  localparam int unsigned MUL_ITER = SIZE;
`endif
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITER - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [SIZE-1:0]  r_mcand;   // multiplicand (MUL) or divisor (DIV)
  logic [SIZE-1:0]  r_acc_hi;  // product high half or partial remainder
  logic [SIZE-1:0]  r_acc_lo;  // multiplier/product low half or dividend/quotient
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_is_div;
  logic [SIZE-1:0]  r_hi;
  logic [SIZE-1:0]  r_lo;

  logic             w_is_mfhi, w_is_mthi, w_is_mflo, w_is_mtlo;
  logic             w_is_mult, w_is_multu, w_is_div, w_is_divu;
  logic             w_md_op;
  logic             w_accept;
  logic             w_start_mul, w_start_div;
  logic             w_signed;
  logic             w_a_neg, w_b_neg;
  logic [SIZE-1:0]  w_abs_a, w_abs_b;

  logic [SIZE-1:0]  w_mul_nxt_hi, w_mul_nxt_lo;
  logic [SIZE:0]    w_div_shift;
  logic             w_div_ge;
  logic [SIZE-1:0]  w_div_rem;
  logic [SIZE-1:0]  w_div_nxt_lo;

  logic [PW-1:0]    w_prod, w_prod_fix;
  logic [SIZE-1:0]  w_quo_fix, w_rem_fix;
  logic [SIZE-1:0]  w_res_hi, w_res_lo;

  // Function decode and operand magnitude for signed operations.
  always_comb begin
    w_is_mfhi   = (funcion == F_MFHI);
    w_is_mthi   = (funcion == F_MTHI);
    w_is_mflo   = (funcion == F_MFLO);
    w_is_mtlo   = (funcion == F_MTLO);
    w_is_mult   = (funcion == F_MULT);
    w_is_multu  = (funcion == F_MULTU);
    w_is_div    = (funcion == F_DIV);
    w_is_divu   = (funcion == F_DIVU);
    w_md_op     = md_valid & (w_is_mfhi | w_is_mthi | w_is_mflo | w_is_mtlo |
                              w_is_mult | w_is_multu | w_is_div | w_is_divu);
    w_accept    = w_md_op & (r_state == S_IDLE);
    w_start_mul = w_accept & (w_is_mult | w_is_multu);
    w_start_div = w_accept & (w_is_div | w_is_divu);
    w_signed    = w_is_mult | w_is_div;
    w_a_neg     = w_signed & op_a[SIZE-1];
    w_b_neg     = w_signed & op_b[SIZE-1];
    w_abs_a     = w_a_neg ? (~op_a + SIZE'(1)) : op_a;
    w_abs_b     = w_b_neg ? (~op_b + SIZE'(1)) : op_b;
  end

`ifdef MULDIV_RADIX4_EN
  logic [SIZE+1:0] w_mul_pp;
  logic [SIZE+1:0] w_mul_sum;

  // Radix-4 shift-add step: add 0..3 times the multiplicand, shift right by two.
  always_comb begin
    w_mul_pp     = (r_acc_lo[0] ? {2'b00, r_mcand} : '0) +
                   (r_acc_lo[1] ? {1'b0, r_mcand, 1'b0} : '0);
    w_mul_sum    = {2'b00, r_acc_hi} + w_mul_pp;
    w_mul_nxt_hi = w_mul_sum[SIZE+1:2];
    w_mul_nxt_lo = {w_mul_sum[1:0], r_acc_lo[SIZE-1:2]};
  end
`else
  logic [SIZE:0] w_mul_sum;

  // Radix-2 shift-add step: conditionally add the multiplicand, shift right by one.
  always_comb begin
    w_mul_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    w_mul_nxt_hi = w_mul_sum[SIZE:1];
    w_mul_nxt_lo = {w_mul_sum[0], r_acc_lo[SIZE-1:1]};
  end
`endif

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_div_shift  = {r_acc_hi, r_acc_lo[SIZE-1]};
    w_div_ge     = (w_div_shift >= {1'b0, r_mcand});
    w_div_rem    = w_div_ge ? SIZE'(w_div_shift - {1'b0, r_mcand}) : w_div_shift[SIZE-1:0];
    w_div_nxt_lo = {r_acc_lo[SIZE-2:0], w_div_ge};
  end

  // Sign fix-up of the finished magnitude result; divide-by-zero forces an all-ones quotient.
  always_comb begin
    w_prod     = {r_acc_hi, r_acc_lo};
    w_prod_fix = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
    w_quo_fix  = r_dz ? '1 : (r_neg_q ? (~r_acc_lo + SIZE'(1)) : r_acc_lo);
    w_rem_fix  = r_neg_r ? (~r_acc_hi + SIZE'(1)) : r_acc_hi;
    w_res_hi   = r_is_div ? w_rem_fix : w_prod_fix[PW-1:SIZE];
    w_res_lo   = r_is_div ? w_quo_fix : w_prod_fix[SIZE-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_state_nxt = S_MUL;
        else if (w_start_div) w_state_nxt = S_DIV;
      end
      S_MUL:  if (r_cnt == MUL_LAST) w_state_nxt = S_DONE;
      S_DIV:  if (r_cnt == DIV_LAST) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status and move-from outputs; HI/LO readers wait through the commit cycle.
  always_comb begin
    busy      = 1'b0;
    md_stall  = 1'b0;
    mf_result = '0;
    busy      = (r_state == S_MUL) | (r_state == S_DIV);
    md_stall  = w_md_op & (busy | (r_state == S_DONE));
    if (w_md_op && !md_stall) begin
      if (w_is_mfhi)      mf_result = r_hi;
      else if (w_is_mflo) mf_result = r_lo;
    end
  end

  // Iteration datapath: operand latch on acceptance, one step per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_cnt    <= '0;
            r_mcand  <= w_abs_a;
            r_acc_hi <= '0;
            r_acc_lo <= w_abs_b;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= 1'b0;
            r_is_div <= 1'b0;
          end else if (w_start_div) begin
            r_cnt    <= '0;
            r_mcand  <= w_abs_b;
            r_acc_hi <= '0;
            r_acc_lo <= w_abs_a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (op_b == '0);
            r_is_div <= 1'b1;
          end
        end
        S_MUL: begin
          r_cnt    <= r_cnt + CNT_W'(1);
          r_acc_hi <= w_mul_nxt_hi;
          r_acc_lo <= w_mul_nxt_lo;
        end
        S_DIV: begin
          r_cnt    <= r_cnt + CNT_W'(1);
          r_acc_hi <= w_div_rem;
          r_acc_lo <= w_div_nxt_lo;
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: move-to writes when idle, result commit in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_DONE) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_accept) begin
      if (w_is_mthi) r_hi <= op_a;
      if (w_is_mtlo) r_lo <= op_a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus queues expected commits and move-from
// values; an independent monitor pops and compares them as the DUT presents results.
module tb_ex_muldiv_unit;

`ifdef MULDIV_RADIX4_EN
  localparam int EXP_STALL = 17;
`else
  localparam int EXP_STALL = 33;
`endif

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_valid;
  logic [5:0]  funcion;
  logic [31:0] op_a, op_b;
  logic        md_stall, busy;
  logic [31:0] mf_result, hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  tag;
  } commit_t;

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  tag;
  } mf_t;

  commit_t q_commit[$];
  mf_t     q_mf[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  ex_muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_valid  (md_valid),
    .funcion   (funcion),
    .op_a      (op_a),
    .op_b      (op_b),
    .md_stall  (md_stall),
    .busy      (busy),
    .mf_result (mf_result),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    md_valid = v;
    funcion  = f;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply/divide, expect the given commit, then let it drain.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int tag);
    q_commit.push_back({ehi, elo, 8'(tag)});
    drive(1'b1, f, a, b);
    tick();
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    repeat (40) tick();
  endtask

  // Hold the current instruction until it stops stalling; returns stalled cycle count.
  task automatic count_stall(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md_stall) cnt++;
      else break;
    end
  endtask

  // Monitor: compares HI/LO one cycle after busy falls, and mf_result on unstalled MFHI/MFLO.
  initial begin : monitor
    logic    prev_busy;
    logic    pending;
    commit_t ce;
    mf_t     me;
    prev_busy = 1'b0;
    pending   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        pending   = 1'b0;
      end else begin
        if (pending) begin
          if (q_commit.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_commit: got hi=0x%08h lo=0x%08h expected none", hi, lo);
          end else begin
            ce = q_commit.pop_front();
            check($sformatf("commit%0d_hi", ce.tag), hi, ce.hi);
            check($sformatf("commit%0d_lo", ce.tag), lo, ce.lo);
          end
          pending = 1'b0;
        end
        if (prev_busy && !busy) pending = 1'b1;
        prev_busy = busy;
        if (md_valid && (funcion == F_MFHI || funcion == F_MFLO) && !md_stall) begin
          if (q_mf.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_mf: got 0x%08h expected none", mf_result);
          end else begin
            me = q_mf.pop_front();
            check($sformatf("mf%0d", me.tag), mf_result, me.val);
          end
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    rst_n = 1'b0;
    drive(1'b1, F_MFHI, 32'h0, 32'h0);
    #12;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(md_stall), 32'h0);
    check("rst_mf", mf_result, 32'h0);
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    run_op(F_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1);

    // MULTU with unrelated ALU instructions overlapping the operation
    q_commit.push_back({32'h00000001, 32'hFFFFFFFE, 8'd2});
    drive(1'b1, F_MULTU, 32'hFFFFFFFF, 32'h2);
    tick();
    drive(1'b1, F_ADD, 32'h5, 32'h6);
    repeat (5) begin
      @(negedge clk);
      check("add_no_stall", 32'(md_stall), 32'h0);
      check("add_busy", 32'(busy), 32'h1);
      @(posedge clk); #1;
    end
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    repeat (35) tick();

    run_op(F_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 3);
    run_op(F_DIVU,  32'd100,      32'h0,        32'd100,      32'hFFFFFFFF, 4);
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 5);
    run_op(F_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 6);
    run_op(F_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 7);
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 8);
    run_op(F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        9);
    run_op(F_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10);

    // MULT 6*7 followed immediately by a dependent MFLO
    q_commit.push_back({32'h0, 32'd42, 8'd11});
    q_mf.push_back({32'd42, 8'd11});
    drive(1'b1, F_MULT, 32'd6, 32'd7);
    tick();
    drive(1'b1, F_MFLO, 32'h0, 32'h0);
    count_stall(cnt);
    check("mflo_stall_cycles", 32'(cnt), 32'(EXP_STALL));
    @(posedge clk); #1;
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    tick();

    // Unknown function code is ignored
    drive(1'b1, 6'h1C, 32'h5, 32'h5);
    @(negedge clk);
    check("unk_stall", 32'(md_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    check("unk_busy", 32'(busy), 32'h0);
    check("unk_hi", hi, 32'h0);
    check("unk_lo", lo, 32'd42);

    // MTLO while idle, then MFLO with no stall
    drive(1'b1, F_MTLO, 32'h1234, 32'h0);
    @(negedge clk);
    check("mtlo_stall", 32'(md_stall), 32'h0);
    @(posedge clk); #1;
    check("mtlo_lo", lo, 32'h1234);
    q_mf.push_back({32'h1234, 8'd13});
    drive(1'b1, F_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("mflo_idle_stall", 32'(md_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    tick();

    // MTHI issued while busy waits for the commit, then overwrites HI
    q_commit.push_back({32'h0, 32'd12, 8'd14});
    drive(1'b1, F_MULT, 32'd3, 32'd4);
    tick();
    drive(1'b1, F_MTHI, 32'hABCD, 32'h0);
    count_stall(cnt);
    check("mthi_stall_cycles", 32'(cnt), 32'(EXP_STALL));
    @(posedge clk); #1;
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_lo", lo, 32'd12);
    tick();

    // Reset in the middle of a divide aborts it
    drive(1'b1, F_DIVU, 32'd100, 32'd7);
    tick();
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    repeat (10) tick();
    check("div_running", 32'(busy), 32'h1);
    drive(1'b1, F_MFHI, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_stall", 32'(md_stall), 32'h0);
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    run_op(F_MULT, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 16);
    q_mf.push_back({32'h1, 8'd17});
    drive(1'b1, F_MFHI, 32'h0, 32'h0);
    tick();
    drive(1'b0, F_ADD, 32'h0, 32'h0);
    repeat (3) tick();

    check("commit_queue_empty", 32'(q_commit.size()), 32'h0);
    check("mf_queue_empty", 32'(q_mf.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
